axi_ctrl_master: RTL and testbench
==================================

Name: axi_ctrl_master

Overview:
Host-side AXI4-Lite initiator that drives a tile's control_S_AXI slave port. It turns single-beat register commands (write or read) from a host command stream into compliant AW/W/B or AR/R transactions and returns one response per command. It sits between the host/test sequencer and each tile's axi_control slave, in the clk_control domain. It is used for rvControl, tile_coordinates and memory-window programming.

Parameters:
BW, 32, AXI data width
BWB, BW/8, write-strobe width
AXI_ADDR, 8, AXI address width
TIMEOUT_W, 16, width of the per-transaction watchdog counter
TIMEOUT_CYCLES, 1024, cycles without completion before the timeout flag sets

Ports:
clk_control  in  1  single clock
clk_control_rst_high  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when cmd_valid=1
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AXI_ADDR  register byte address
cmd_wdata  in  BW  write data
cmd_wstrb  in  BWB  write strobes
rsp_valid  out  1  response present
rsp_ready  in  1  host accepts response
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  BW  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP
busy  out  1  transaction in flight
err_timeout  out  1  sticky watchdog flag, cleared only by reset
control_M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  AXI_ADDR/1/1  write address channel
control_M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  BW/BWB/1/1  write data channel
control_M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
control_M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  AXI_ADDR/1/1  read address channel
control_M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  BW/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync deassert usage): state=IDLE. All VALID/READY outputs and rsp_valid, busy, err_timeout = 0. Address/data/rsp registers = 0.
- Exactly one outstanding transaction. cmd_ready=1 only in IDLE.
- IDLE: on cmd_valid, register the command. Go to WR if cmd_write=1, else RD_ADDR. Set busy=1.
- WR: AWVALID and WVALID assert the cycle after acceptance. Each stays high, with payload stable, until its own READY is sampled high; then it drops independently. AW and W may complete in either order or the same cycle. When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, capture BRESP into rsp_resp, set rsp_rdata=0, go to RSP.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP: rsp_valid=1 with fields stable until rsp_ready. Return to IDLE the same edge; busy drops then.
- Minimum latency with a zero-wait slave: write takes 4 cycles from cmd accept to rsp_valid; read takes 4.
- No VALID is ever withdrawn before its handshake, including after a timeout (AXI compliance).
- Watchdog: counter clears on cmd accept and increments each cycle in WR/WR_RESP/RD_ADDR/RD_DATA. When it reaches TIMEOUT_CYCLES, err_timeout sets (sticky) and the counter saturates. The transaction continues.
- Unsolicited BVALID/RVALID outside WR_RESP/RD_DATA: ignored, READY stays 0.
- Reset mid-transaction: all VALIDs drop immediately (asynchronous) and the pending response is lost.
- Non-OKAY resp values (SLVERR=2, DECERR=3) are passed through to the host without retry.

Decomposition:
- Package axi_ctrl_pkg: state enum (IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP), RESP_OKAY/EXOKAY/SLVERR/DECERR constants, and the command/response struct typedefs.
- No sub-module needed. The watchdog is inline. An optional axi_ctrl_watchdog counter sub-module is acceptable if it is reused elsewhere.

Test Plan:
- Write addr 0x04, data 0x0000_0001, wstrb 0xF, zero-wait slave -> AWADDR=0x04 and WDATA=1 handshake in cycle 1. rsp_valid at cycle 4 with rsp_write=1, rsp_resp=0.
- Read addr 0x08, slave returns RDATA 0x0000_0012 after 3 wait cycles -> rsp_rdata=0x12, rsp_resp=0, busy=1 throughout until rsp handshake.
- Write with AWREADY delayed 5 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 6 cycles with stable AWADDR, single B handshake.
- Slave returns BRESP=2 -> rsp_resp=2, next command is accepted normally.
- TIMEOUT_CYCLES=16, slave never asserts ARREADY -> err_timeout=1 at cycle 16, ARVALID still 1. Late ARREADY/RVALID completes the read; err_timeout stays 1 until reset.
- Reset asserted while in WR_RESP, then cmd held with rsp_ready=0 -> outputs all 0 immediately, cmd_ready=1 after release. The held rsp_valid stays stable until rsp_ready.

Source files
------------

// File: rtl/axi_ctrl_pkg.sv
// Shared types for the host-side AXI4-Lite control initiator.
// FSM encodings, AXI response codes and command/response bundles.
package axi_ctrl_pkg;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t S_IDLE    = 3'd0;
  localparam ctrl_state_t S_WR      = 3'd1;
  localparam ctrl_state_t S_WR_RESP = 3'd2;
  localparam ctrl_state_t S_RD_ADDR = 3'd3;
  localparam ctrl_state_t S_RD_DATA = 3'd4;
  localparam ctrl_state_t S_RSP     = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam int CTRL_BW   = 32;
  localparam int CTRL_ADDR = 8;

  typedef struct packed {
    logic                   write;
    logic [CTRL_ADDR-1:0]   addr;
    logic [CTRL_BW-1:0]     wdata;
    logic [CTRL_BW/8-1:0]   wstrb;
  } ctrl_cmd_t;

  typedef struct packed {
    logic                   write;
    logic [CTRL_BW-1:0]     rdata;
    logic [1:0]             resp;
  } ctrl_rsp_t;

  function automatic logic in_flight(
    input ctrl_state_t s
  );
    return (s == S_WR) || (s == S_WR_RESP) ||
           (s == S_RD_ADDR) || (s == S_RD_DATA);
  endfunction

endpackage

// File: rtl/axi_ctrl_master.sv
// Single-outstanding AXI4-Lite initiator for tile control registers.
// One host command in, one AW/W/B or AR/R exchange, one response out.
module axi_ctrl_master
  import axi_ctrl_pkg::*;
#(
  parameter int BW             = 32,
  parameter int BWB            = BW/8,
  parameter int AXI_ADDR       = 8,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk_control,
  input  logic                clk_control_rst_high,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AXI_ADDR-1:0] cmd_addr,
  input  logic [BW-1:0]       cmd_wdata,
  input  logic [BWB-1:0]      cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [BW-1:0]       rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic                err_timeout,
  output logic [AXI_ADDR-1:0] control_M_AXI_AWADDR,
  output logic                control_M_AXI_AWVALID,
  input  logic                control_M_AXI_AWREADY,
  output logic [BW-1:0]       control_M_AXI_WDATA,
  output logic [BWB-1:0]      control_M_AXI_WSTRB,
  output logic                control_M_AXI_WVALID,
  input  logic                control_M_AXI_WREADY,
  input  logic [1:0]          control_M_AXI_BRESP,
  input  logic                control_M_AXI_BVALID,
  output logic                control_M_AXI_BREADY,
  output logic [AXI_ADDR-1:0] control_M_AXI_ARADDR,
  output logic                control_M_AXI_ARVALID,
  input  logic                control_M_AXI_ARREADY,
  input  logic [BW-1:0]       control_M_AXI_RDATA,
  input  logic [1:0]          control_M_AXI_RRESP,
  input  logic                control_M_AXI_RVALID,
  output logic                control_M_AXI_RREADY
);

  localparam logic [TIMEOUT_W-1:0] WD_MAX =
    TIMEOUT_W'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_W-1:0] WD_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t          state;
  logic                 aw_pend;
  logic                 w_pend;
  logic [AXI_ADDR-1:0]  addr_q;
  logic [BW-1:0]        wdata_q;
  logic [BWB-1:0]       wstrb_q;
  logic                 write_q;
  logic [BW-1:0]        rdata_q;
  logic [1:0]           resp_q;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 err_q;
  logic                 aw_ok;
  logic                 w_ok;

  // Ready gated by reset so nothing is accepted while held in reset.
  assign cmd_ready = (state == S_IDLE) && !clk_control_rst_high;
  assign rsp_valid = (state == S_RSP);
  assign busy      = (state != S_IDLE);

  assign rsp_write   = write_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign err_timeout = err_q;

  assign control_M_AXI_AWADDR  = addr_q;
  assign control_M_AXI_ARADDR  = addr_q;
  assign control_M_AXI_WDATA   = wdata_q;
  assign control_M_AXI_WSTRB   = wstrb_q;
  assign control_M_AXI_AWVALID = aw_pend;
  assign control_M_AXI_WVALID  = w_pend;
  assign control_M_AXI_BREADY  = (state == S_WR_RESP);
  assign control_M_AXI_ARVALID = (state == S_RD_ADDR);
  assign control_M_AXI_RREADY  = (state == S_RD_DATA);

  assign aw_ok = !aw_pend || control_M_AXI_AWREADY;
  assign w_ok  = !w_pend || control_M_AXI_WREADY;

  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      state   <= S_IDLE;
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            write_q <= cmd_write;
            aw_pend <= cmd_write;
            w_pend  <= cmd_write;
            state   <= cmd_write ? S_WR : S_RD_ADDR;
          end
        end
        S_WR: begin
          // AW and W retire independently; leave once both are done.
          if (control_M_AXI_AWREADY) aw_pend <= 1'b0;
          if (control_M_AXI_WREADY)  w_pend  <= 1'b0;
          if (aw_ok && w_ok) state <= S_WR_RESP;
        end
        S_WR_RESP: begin
          if (control_M_AXI_BVALID) begin
            resp_q  <= control_M_AXI_BRESP;
            rdata_q <= '0;
            state   <= S_RSP;
          end
        end
        S_RD_ADDR: begin
          if (control_M_AXI_ARREADY) state <= S_RD_DATA;
        end
        S_RD_DATA: begin
          if (control_M_AXI_RVALID) begin
            rdata_q <= control_M_AXI_RDATA;
            resp_q  <= control_M_AXI_RRESP;
            state   <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Watchdog only flags; the transaction is never abandoned.
  always_ff @(posedge clk_control or posedge clk_control_rst_high) begin
    if (clk_control_rst_high) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      wd_cnt <= '0;
    end else if (in_flight(state) && wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_ctrl_master.sv
// Bench for axi_ctrl_master: vector table, corner sequences, random
// traffic against a memory-backed slave and a shadow register model.
module tb_axi_ctrl_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        busy;
  logic        err_timeout;
  logic [7:0]  awaddr;
  logic        awv;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wv;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic [7:0]  araddr;
  logic        arv;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  axi_ctrl_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk_control(clk),
    .clk_control_rst_high(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp),
    .busy(busy),
    .err_timeout(err_timeout),
    .control_M_AXI_AWADDR(awaddr),
    .control_M_AXI_AWVALID(awv),
    .control_M_AXI_AWREADY(awready),
    .control_M_AXI_WDATA(wdata),
    .control_M_AXI_WSTRB(wstrb),
    .control_M_AXI_WVALID(wv),
    .control_M_AXI_WREADY(wready),
    .control_M_AXI_BRESP(bresp),
    .control_M_AXI_BVALID(bvalid),
    .control_M_AXI_BREADY(bready),
    .control_M_AXI_ARADDR(araddr),
    .control_M_AXI_ARVALID(arv),
    .control_M_AXI_ARREADY(arready),
    .control_M_AXI_RDATA(rdata),
    .control_M_AXI_RRESP(rresp),
    .control_M_AXI_RVALID(rvalid),
    .control_M_AXI_RREADY(rready)
  );

  // Slave knobs, set by the test before each command.
  int          k_aw = 0, k_w = 0, k_b = 0, k_ar = 0, k_r = 0;
  logic [1:0]  k_bresp = '0, k_rresp = '0;
  logic [31:0] k_rdata = '0;
  bit          use_mem = 1'b0;
  bit          force_b = 1'b0, force_r = 1'b0;

  int          aw_wait, w_wait, b_wait, ar_wait, r_wait;
  bit          aw_got, w_got, ar_got;
  logic [7:0]  sl_awaddr, sl_araddr;
  logic [31:0] sl_wdata;
  logic [3:0]  sl_wstrb;
  logic [31:0] mem [64];
  logic [31:0] shadow [64];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      aw_got = 0; w_got = 0; ar_got = 0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      ar_wait = 0; r_wait = 0;
    end else begin
      if (bvalid && bready) begin
        mem[sl_awaddr[7:2]] =
          merge(mem[sl_awaddr[7:2]], sl_wdata, sl_wstrb);
        aw_got = 0; w_got = 0; b_wait = 0;
      end else if (aw_got && w_got) b_wait++;
      if (rvalid && rready) begin
        ar_got = 0; r_wait = 0;
      end else if (ar_got) r_wait++;
      if (awv) begin
        if (awready) begin
          aw_got = 1; aw_wait = 0; sl_awaddr = awaddr;
        end else aw_wait++;
      end
      if (wv) begin
        if (wready) begin
          w_got = 1; w_wait = 0;
          sl_wdata = wdata; sl_wstrb = wstrb;
        end else w_wait++;
      end
      if (arv) begin
        if (arready) begin
          ar_got = 1; ar_wait = 0; sl_araddr = araddr;
        end else ar_wait++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0;
      bvalid = 0; rvalid = 0;
    end else begin
      awready = awv && (aw_wait >= k_aw);
      wready  = wv && (w_wait >= k_w);
      arready = arv && (ar_wait >= k_ar);
      bvalid  = force_b || (aw_got && w_got && b_wait >= k_b);
      bresp   = k_bresp;
      rvalid  = force_r || (ar_got && r_wait >= k_r);
      rresp   = k_rresp;
      rdata   = use_mem ? mem[sl_araddr[7:2]] : k_rdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  bit          p_aw, p_w, p_ar;
  logic [7:0]  p_awaddr, p_araddr;
  logic [35:0] p_wpay;
  int          aw_cyc, w_cyc, b_hs;

  // Handshake stability: a stalled VALID must persist unchanged.
  task automatic mon();
    if (rst) begin
      p_aw = 0; p_w = 0; p_ar = 0;
      return;
    end
    if (p_aw) chk("aw_hold", {awv, awaddr}, {1'b1, p_awaddr});
    if (p_w)  chk("w_hold", {wv, wstrb, wdata}, {1'b1, p_wpay});
    if (p_ar) chk("ar_hold", {arv, araddr}, {1'b1, p_araddr});
    p_aw = awv && !awready;
    p_w  = wv && !wready;
    p_ar = arv && !arready;
    p_awaddr = awaddr;
    p_araddr = araddr;
    p_wpay = {wstrb, wdata};
    if (awv) aw_cyc++;
    if (wv) w_cyc++;
    if (bvalid && bready) b_hs++;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    mon();
  endtask

  task automatic send_cmd(
    input bit          wr,
    input logic [7:0]  a,
    input logic [31:0] d,
    input logic [3:0]  s
  );
    int n;
    cmd_valid = 1; cmd_write = wr;
    cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("cmd_accept", cmd_ready, 1);
    step();
    cmd_valid = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          k_aw, k_w, k_b, k_ar, k_r;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          rsp_dly;
    int          lat;
    bit          use_mem;
  } vec_t;

  function automatic vec_t mk(
    input bit wr, input logic [7:0] a,
    input logic [31:0] d, input logic [3:0] s,
    input int aw, input int w, input int b,
    input int ar, input int r,
    input logic [1:0] resp, input logic [31:0] rd,
    input int dly, input int lat
  );
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.k_aw = aw; v.k_w = w; v.k_b = b;
    v.k_ar = ar; v.k_r = r;
    v.resp = resp; v.rdata = rd;
    v.rsp_dly = dly; v.lat = lat; v.use_mem = 0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] exp_rd;
    logic [34:0] snap;
    int k;
    bit busy_ok, stable_ok;
    k_aw = v.k_aw; k_w = v.k_w; k_b = v.k_b;
    k_ar = v.k_ar; k_r = v.k_r;
    k_bresp = v.resp; k_rresp = v.resp;
    k_rdata = v.rdata; use_mem = v.use_mem;
    exp_rd = v.wr ? 32'h0 :
      (v.use_mem ? shadow[v.addr[7:2]] : v.rdata);
    aw_cyc = 0; w_cyc = 0; b_hs = 0;
    send_cmd(v.wr, v.addr, v.data, v.strb);
    k = 1;
    busy_ok = 1;
    while (!rsp_valid && k < 300) begin
      if (!busy) busy_ok = 0;
      step();
      k++;
    end
    chk("rsp_arrive", rsp_valid, 1);
    if (v.lat != 0) chk("latency", k + 1, v.lat);
    chk("rsp_write", rsp_write, v.wr);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_resp", rsp_resp, v.resp);
    if (v.wr) begin
      chk("aw_cycles", aw_cyc, v.k_aw + 1);
      chk("w_cycles", w_cyc, v.k_w + 1);
      chk("b_count", b_hs, 1);
      chk("awaddr", sl_awaddr, v.addr);
      chk("wpay", {sl_wstrb, sl_wdata}, {v.strb, v.data});
      shadow[v.addr[7:2]] =
        merge(shadow[v.addr[7:2]], v.data, v.strb);
    end else begin
      chk("araddr", sl_araddr, v.addr);
    end
    snap = {rsp_write, rsp_resp, rsp_rdata};
    stable_ok = 1;
    repeat (v.rsp_dly) begin
      step();
      if (!rsp_valid || {rsp_write, rsp_resp, rsp_rdata} !== snap)
        stable_ok = 0;
      if (!busy) busy_ok = 0;
    end
    chk("busy_held", busy_ok, 1);
    if (v.rsp_dly != 0) chk("rsp_stable", stable_ok, 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("rsp_done", {rsp_valid, busy, cmd_ready}, 3'b001);
  endtask

  vec_t tbl[10];

  initial begin
    int n;
    logic [34:0] snap;
    bit stable_ok;
    vec_t v;

    tbl[0] = mk(1, 8'h04, 32'h1, 4'hF, 0,0,0,0,0, 2'd0, 0, 0, 4);
    tbl[1] = mk(0, 8'h08, 0, 0, 0,0,0,0,3, 2'd0, 32'h12, 0, 0);
    tbl[2] = mk(1, 8'h0C, 32'hDEADBEEF, 4'hF, 5,0,0,0,0,
                2'd0, 0, 0, 0);
    tbl[3] = mk(1, 8'h10, 32'h55, 4'hF, 0,4,1,0,0, 2'd0, 0, 0, 0);
    tbl[4] = mk(1, 8'h14, 32'hCAFE0001, 4'hC, 2,2,0,0,0,
                2'd0, 0, 1, 0);
    tbl[5] = mk(1, 8'h18, 32'h77, 4'hF, 0,0,0,0,0, 2'd2, 0, 0, 0);
    tbl[6] = mk(0, 8'h1C, 0, 0, 0,0,0,0,0, 2'd0, 32'hA5A5, 0, 4);
    tbl[7] = mk(0, 8'h20, 0, 0, 0,0,0,2,1, 2'd3, 32'hBAD, 0, 0);
    tbl[8] = mk(1, 8'h24, 32'h1234, 4'h3, 1,0,2,0,0,
                2'd3, 0, 3, 0);
    tbl[9] = mk(0, 8'h28, 0, 0, 0,0,0,1,0, 2'd2, 32'h9, 2, 0);

    rst = 1;
    step();
    chk("reset_outs",
        {awv, wv, arv, bready, rready, rsp_valid, busy,
         err_timeout, cmd_ready, rsp_rdata, rsp_resp},
        '0);
    step();
    rst = 0;
    step();
    chk("idle_ready", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    chk("no_timeout", err_timeout, 0);

    // Unsolicited B/R while idle must not be accepted.
    force_b = 1; force_r = 1;
    repeat (3) begin
      step();
      chk("unsol_ready", {bready, rready, busy}, 3'b000);
    end
    force_b = 0; force_r = 0;
    step();

    // Read against a slave that withholds ARREADY.
    k_aw = 0; k_w = 0; k_b = 0; k_r = 0; k_ar = 1000;
    use_mem = 0; k_rdata = 32'h77; k_rresp = 2'd0;
    send_cmd(0, 8'h30, 0, 0);
    repeat (15) step();
    chk("wd_before", err_timeout, 0);
    step();
    chk("wd_set", {err_timeout, arv}, 2'b11);
    k_ar = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk("wd_rsp", {rsp_valid, rsp_resp, rsp_rdata},
        {1'b1, 2'd0, 32'h77});
    chk("wd_sticky", err_timeout, 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    run_vec(tbl[6]);
    chk("wd_sticky2", err_timeout, 1);

    // Reset while waiting on B; command is held through reset.
    k_b = 50; k_bresp = 2'd0;
    send_cmd(1, 8'h2C, 32'hF00D, 4'hF);
    n = 0;
    while (!bready && n < 20) begin
      step();
      n++;
    end
    chk("reach_wr_resp", bready, 1);
    rst = 1;
    cmd_valid = 1; cmd_write = 1;
    cmd_addr = 8'h34; cmd_wdata = 32'h1234; cmd_wstrb = 4'hF;
    #1;
    chk("async_rst",
        {awv, wv, arv, bready, rready, rsp_valid, busy,
         err_timeout, cmd_ready},
        '0);
    k_b = 0;
    step();
    step();
    chk("rst_hold_ready", cmd_ready, 0);
    rst = 0;
    #1;
    chk("rel_ready", cmd_ready, 1);
    step();
    cmd_valid = 0;
    shadow[13] = merge(shadow[13], 32'h1234, 4'hF);
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk("post_rst_rsp", {rsp_valid, rsp_write, rsp_resp, rsp_rdata},
        {1'b1, 1'b1, 2'd0, 32'h0});
    chk("post_rst_addr", sl_awaddr, 8'h34);
    snap = {rsp_write, rsp_resp, rsp_rdata};
    stable_ok = 1;
    repeat (5) begin
      step();
      if (!rsp_valid || {rsp_write, rsp_resp, rsp_rdata} !== snap)
        stable_ok = 0;
    end
    chk("held_rsp", stable_ok, 1);
    rsp_ready = 1;
    step();
    rsp_ready = 0;
    chk("held_done", {rsp_valid, busy, cmd_ready}, 3'b001);

    // Random traffic through a memory-backed slave.
    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom_range(0, 1));
      v.addr = 8'($urandom_range(0, 7) * 4);
      v.data = $urandom;
      v.strb = 4'($urandom_range(1, 15));
      v.k_aw = $urandom_range(0, 3);
      v.k_w = $urandom_range(0, 3);
      v.k_b = $urandom_range(0, 3);
      v.k_ar = $urandom_range(0, 3);
      v.k_r = $urandom_range(0, 3);
      v.resp = 2'($urandom_range(0, 3));
      v.rdata = '0;
      v.rsp_dly = $urandom_range(0, 2);
      v.lat = 0;
      v.use_mem = 1;
      run_vec(v);
    end
    chk("rand_no_timeout", err_timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
